// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - WIDTH-generic signed/unsigned radix-2 restoring divider with valid/ready handshakes
//
// Purpose:
//    Multi-cycle divider with fixed latency. Operands are accepted in IDLE and
//    converted to magnitudes. CALC then produces one quotient bit per clock over
//    WIDTH clocks. FIX applies the sign correction and registers the result.
//    DONE holds the result until the consumer accepts it. Quotient rounds toward
//    zero and the remainder takes the sign of the dividend, matching Verilog
//    / and %.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   operands present on Dividend/Divisor
//    in_ready   divider idle and able to accept operands
//    Dividend   dividend (WIDTH bits)
//    Divisor    divisor (WIDTH bits)
//    out_valid  Quotient/Remain/error/ovf valid
//    out_ready  consumer accepts the result
//    Quotient   quotient (WIDTH bits)
//    Remain     remainder (WIDTH bits)
//    error      divisor was zero
//    ovf        signed overflow (most-negative / -1)
//    busy       any state other than IDLE

module seq_divider #(
   parameter int WIDTH  = 16,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remain,
   output logic             error,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   // The counter runs 0..WIDTH-1, so $clog2(WIDTH) bits are enough.
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quo_q;      // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH:0]   acc_q;      // partial remainder
   logic [WIDTH:0]   dvs_q;      // divisor magnitude, one bit wider so |most-negative| fits
   logic [WIDTH-1:0] dvd_q;      // raw dividend, returned as the remainder on divide-by-zero
   logic             sq_q;       // quotient sign
   logic             sr_q;       // remainder sign
   logic             dz_q;       // divisor was zero
   logic             ovf_pend_q; // most-negative / -1 detected at capture

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH+1:0] shifted, trial;
   logic             last_iter;

   // Operand magnitudes. Negating the most-negative value yields the same bit
   // pattern, which read as unsigned is exactly its magnitude.
   assign dvd_neg = SIGNED && Dividend[WIDTH-1];
   assign dvs_neg = SIGNED && Divisor[WIDTH-1];
   assign dvd_mag = dvd_neg ? -Dividend : Dividend;
   assign dvs_mag = dvs_neg ? -Divisor : Divisor;

   // One restoring step: bring in the next dividend bit, then try to subtract
   // the divisor. A borrow in the top bit means the subtraction is undone.
   assign shifted   = {acc_q, quo_q[WIDTH-1]};
   assign trial     = shifted - {1'b0, dvs_q};
   assign last_iter = (cnt_q == CW'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (last_iter) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         quo_q      <= '0;
         acc_q      <= '0;
         dvs_q      <= '0;
         dvd_q      <= '0;
         sq_q       <= 1'b0;
         sr_q       <= 1'b0;
         dz_q       <= 1'b0;
         ovf_pend_q <= 1'b0;
         out_valid  <= 1'b0;
         Quotient   <= '0;
         Remain     <= '0;
         error      <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cnt_q      <= '0;
                  quo_q      <= dvd_mag;
                  acc_q      <= '0;
                  dvs_q      <= {1'b0, dvs_mag};
                  dvd_q      <= Dividend;
                  sq_q       <= dvd_neg ^ dvs_neg;
                  sr_q       <= dvd_neg;
                  dz_q       <= (Divisor == '0);
                  ovf_pend_q <= SIGNED && (Dividend == MOST_NEG) && (Divisor == '1);
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q + CW'(1);
               if (trial[WIDTH+1]) begin
                  acc_q <= shifted[WIDTH:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end else begin
                  acc_q <= trial[WIDTH:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end
            end
            S_FIX: begin
               out_valid <= 1'b1;
               if (dz_q) begin
                  Quotient <= '0;
                  Remain   <= dvd_q;
                  error    <= 1'b1;
                  ovf      <= 1'b0;
               end else begin
                  // most-negative / -1 needs no special path: the magnitude
                  // quotient 2^(WIDTH-1) with sq=0 is already the wrapped result.
                  Quotient <= sq_q ? -quo_q : quo_q;
                  Remain   <= sr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  error    <= 1'b0;
                  ovf      <= ovf_pend_q;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  error     <= 1'b0;
                  ovf       <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle divider for the ODE datapath. It replaces the fixed 16-bit signed divider with a WIDTH-generic, signed/unsigned-selectable radix-2 iterative unit. It uses valid/ready handshakes on both sides, fixed latency, and separate divide-by-zero and overflow flags. One division is in flight at a time; results are held until the consumer accepts them.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SIGNED, 1, 1 = two's-complement operands/results; 0 = unsigned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands present on Dividend/Divisor
in_ready  out  1  divider can accept operands
Dividend  in  WIDTH  dividend
Divisor  in  WIDTH  divisor
out_valid  out  1  Quotient/Remain/error/ovf valid
out_ready  in  1  consumer accepts result
Quotient  out  WIDTH  quotient
Remain  out  WIDTH  remainder
error  out  1  divisor was zero
ovf  out  1  signed overflow (most-negative / -1)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0. Quotient, Remain, error and ovf are all 0. The iteration counter and working registers are cleared.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture operands, then go to CALC.
  - CALC: WIDTH iterations, one quotient bit per clock, shift-subtract (restoring) on operand magnitudes. After the last iteration, go to FIX.
  - FIX: apply sign correction, register outputs, set out_valid=1, then go to DONE.
  - DONE: hold all outputs stable while out_valid=1. When out_ready=1, clear out_valid and go to IDLE.
- Capture: when SIGNED=1, store the magnitudes |Dividend| and |Divisor|, plus sign bits sq = sign(Dividend) xor sign(Divisor) and sr = sign(Dividend). When SIGNED=0, use the raw operands with sq=sr=0. Magnitude registers are WIDTH+1 bits so that |most-negative| is representable.
- Arithmetic:
  - Truncating division, matching Verilog / and %.
  - Quotient rounds toward zero.
  - Remainder takes the sign of the Dividend.
  - Dividend = Quotient*Divisor + Remain, and |Remain| < |Divisor|.
- Latency: operands accepted at edge k give out_valid=1 after edge k+WIDTH+1 (17 cycles at WIDTH=16). Latency is fixed and independent of operand values.
- Divisor==0: runs the full latency. Result is error=1, Quotient=0, Remain=Dividend, ovf=0.
- SIGNED=1, Dividend=most-negative, Divisor=-1: Quotient=most-negative (wraps), Remain=0, ovf=1, error=0.
- Flags error and ovf are valid only with out_valid and are cleared on leaving DONE.
- in_ready=0 in CALC, FIX and DONE. in_valid in those states is ignored and is not queued.
- A new operation can be accepted no earlier than the cycle after the DONE→IDLE handshake. Throughput is one result per WIDTH+3 cycles with out_ready held at 1.
- Back-pressure: DONE persists indefinitely while out_ready=0. Outputs must not change.
- out_ready in any state other than DONE has no effect.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is ever presented.
- Operand inputs are sampled only on the accept edge. Later changes to Dividend/Divisor do not affect the operation in flight.

Test Plan:
- WIDTH=16, SIGNED=1, 100/7 → Quotient=14, Remain=2, error=0, ovf=0, out_valid exactly 17 cycles after the accept edge.
- Sign combinations: -100/7 → -14,-2; 100/-7 → -14,2; -100/-7 → 14,-2. Then -32768/-1 → Quotient=-32768, Remain=0, ovf=1.
- Divide by zero: 1234/0 → error=1, Quotient=0, Remain=1234, same 17-cycle latency. The next op 9/3 → 3,0 with error=0.
- SIGNED=0, WIDTH=16: 65535/2 → 32767 rem 1. WIDTH=8, SIGNED=1: -128/3 → -42 rem -2.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready returns to IDLE, and the next accept works.
- Reset mid-CALC (rst_n low at iteration 5) → immediate in_ready=1, out_valid=0, outputs 0. A subsequent 50/5 → 10,0 with correct latency.
- Randomised self-check: 10,000 operand pairs compared against Verilog /, % (with the zero and overflow cases mapped as above), with random out_ready stalls.
